// File: rtl/mxu_result_drain.sv
// mxu_result_drain
//   Result drain stage behind the temporal MXU.
//
//   On each rising edge of mat_valid, the full DIM x DIM result matrix is
//   copied into a local snapshot buffer. The MXU output is then free to be
//   overwritten while the snapshot streams out on a valid/ready port, one
//   element per handshake. Each element is tagged with its row, its column
//   and a last flag.
//
//   A capture that arrives while a snapshot is still draining is dropped,
//   and it sets the sticky overflow flag. One exception: a capture in the
//   same cycle as the final handshake is accepted back-to-back, so m_valid
//   stays high.
//
//   Build option: define MXU_DRAIN_COL_MAJOR_EN to stream in column-major
//   order. The row index advances first. Without the macro the order is
//   row-major, and the column index advances first.
module mxu_result_drain #(
  parameter int DIM           = 4,
  parameter int BIT_WIDTH     = 4,
  parameter int OUT_BIT_WIDTH = 2 * BIT_WIDTH,
  parameter int DIM_BITS      = $clog2(DIM)
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [DIM-1:0][DIM-1:0][OUT_BIT_WIDTH-1:0]  mat_in,
  input  logic                                        mat_valid,
  output logic [OUT_BIT_WIDTH-1:0]                    m_data,
  output logic [DIM_BITS-1:0]                         m_row,
  output logic [DIM_BITS-1:0]                         m_col,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic                                        m_last,
  output logic                                        busy,
  output logic                                        overflow
);

  localparam logic [DIM_BITS-1:0] IDX_MAX  = DIM_BITS'(DIM - 1);
  localparam logic [DIM_BITS-1:0] IDX_ZERO = {DIM_BITS{1'b0}};
  localparam logic [DIM_BITS-1:0] IDX_ONE  = DIM_BITS'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                                      state_r;
  state_t                                      state_nxt_s;
  logic [DIM-1:0][DIM-1:0][OUT_BIT_WIDTH-1:0]  buf_r;
  logic [DIM_BITS-1:0]                         row_r;
  logic [DIM_BITS-1:0]                         col_r;
  logic [DIM_BITS-1:0]                         row_nxt_s;
  logic [DIM_BITS-1:0]                         col_nxt_s;
  logic [DIM_BITS-1:0]                         row_adv_s;
  logic [DIM_BITS-1:0]                         col_adv_s;
  logic                                        mat_valid_q_r;
  logic                                        capture_s;
  logic                                        hs_s;
  logic                                        last_idx_s;
  logic                                        load_s;
  logic                                        ovf_nxt_s;

  // Only a 0->1 transition of mat_valid counts as a new result.
  assign capture_s  = mat_valid & ~mat_valid_q_r;
  assign hs_s       = m_valid & m_ready;
  assign last_idx_s = (row_r == IDX_MAX) && (col_r == IDX_MAX);

  // Output data is a plain read of the snapshot at the current index registers.
  assign m_data = buf_r[row_r][col_r];
  assign m_row  = row_r;
  assign m_col  = col_r;

  // Index that follows the current one in streaming order (never used on the final element).
  always_comb begin
    row_adv_s = row_r;
    col_adv_s = col_r;
`ifdef MXU_DRAIN_COL_MAJOR_EN
    if (row_r == IDX_MAX) begin
      row_adv_s = IDX_ZERO;
      col_adv_s = col_r + IDX_ONE;
    end else begin
      row_adv_s = row_r + IDX_ONE;
    end
`else
    if (col_r == IDX_MAX) begin
      col_adv_s = IDX_ZERO;
      row_adv_s = row_r + IDX_ONE;
    end else begin
      col_adv_s = col_r + IDX_ONE;
    end
`endif
  end

  // Next-state, index, snapshot-load and overflow decisions.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    load_s      = 1'b0;
    ovf_nxt_s   = overflow;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          load_s      = 1'b1;
          row_nxt_s   = IDX_ZERO;
          col_nxt_s   = IDX_ZERO;
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (hs_s && last_idx_s) begin
          row_nxt_s = IDX_ZERO;
          col_nxt_s = IDX_ZERO;
          if (capture_s) begin
            // A capture on the final handshake is accepted: reload and keep streaming.
            load_s      = 1'b1;
            state_nxt_s = ST_STREAM;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (hs_s) begin
          row_nxt_s = row_adv_s;
          col_nxt_s = col_adv_s;
        end else begin
          state_nxt_s = ST_STREAM;
        end
        // Any other capture while streaming is dropped and remembered.
        if (capture_s && !(hs_s && last_idx_s)) begin
          ovf_nxt_s = 1'b1;
        end else begin
          ovf_nxt_s = overflow;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        row_nxt_s   = IDX_ZERO;
        col_nxt_s   = IDX_ZERO;
      end
    endcase
  end

  // Control registers; port flags are registered from the next-state decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      row_r         <= IDX_ZERO;
      col_r         <= IDX_ZERO;
      mat_valid_q_r <= 1'b0;
      m_valid       <= 1'b0;
      busy          <= 1'b0;
      m_last        <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      row_r         <= row_nxt_s;
      col_r         <= col_nxt_s;
      mat_valid_q_r <= mat_valid;
      m_valid       <= (state_nxt_s == ST_STREAM);
      busy          <= (state_nxt_s == ST_STREAM);
      m_last        <= (state_nxt_s == ST_STREAM) &&
                       (row_nxt_s == IDX_MAX) && (col_nxt_s == IDX_MAX);
      overflow      <= ovf_nxt_s;
    end
  end

  // Snapshot buffer: loaded only on an accepted capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_r <= '0;
    end else if (load_s) begin
      buf_r <= mat_in;
    end else begin
      buf_r <= buf_r;
    end
  end

endmodule

// File: tb/tb_mxu_result_drain.sv
// Testbench for mxu_result_drain.
// The scoreboard queue is filled with the expected element order each time
// a capture is driven. Handshakes are popped from it and compared on the
// falling clock edge.
module tb_mxu_result_drain;

  localparam int DIM = 4;
  localparam int W   = 8;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   row;
    logic [1:0]   col;
    logic         last;
  } exp_t;

  logic                          clk;
  logic                          reset_n;
  logic [DIM-1:0][DIM-1:0][W-1:0] mat_in;
  logic                          mat_valid;
  logic [W-1:0]                  m_data;
  logic [1:0]                    m_row;
  logic [1:0]                    m_col;
  logic                          m_valid;
  logic                          m_ready;
  logic                          m_last;
  logic                          busy;
  logic                          overflow;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  logic         stall_q;
  logic [W-1:0] data_q;
  logic [1:0]   row_q;
  logic [1:0]   col_q;

  mxu_result_drain #(.DIM(4), .BIT_WIDTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mat_in    (mat_in),
    .mat_valid (mat_valid),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mat_seq();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        mat_in[r][c] = 8'(16 * r + c);
  endtask

  task automatic set_mat_const(input logic [W-1:0] v);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        mat_in[r][c] = v;
  endtask

  // Expected stream for the current mat_in, in the configured order.
  task automatic push_expected();
    exp_t e;
    int r;
    int c;
    for (int k = 0; k < DIM * DIM; k++) begin
`ifdef MXU_DRAIN_COL_MAJOR_EN
      r = k % DIM;
      c = k / DIM;
`else
      r = k / DIM;
      c = k % DIM;
`endif
      e.data = mat_in[r][c];
      e.row  = 2'(r);
      e.col  = 2'(c);
      e.last = (k == DIM * DIM - 1);
      sb.push_back(e);
    end
  endtask

  // Run until the scoreboard empties. Mode 0 holds ready high; mode 1 uses the 1,0,0 pattern.
  task automatic drain(input int mode, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      m_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      step();
      n++;
    end
    check_val("drain_timeout", 32'(sb.size()), 32'd0);
    m_ready = 1'b1;
  endtask

  // Scoreboard compare on each handshake, plus hold-stability during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && m_valid) begin
        check_val("stall_data", 32'(m_data), 32'(data_q));
        check_val("stall_row", 32'(m_row), 32'(row_q));
        check_val("stall_col", 32'(m_col), 32'(col_q));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("beat_data", 32'(m_data), 32'(e.data));
          check_val("beat_row", 32'(m_row), 32'(e.row));
          check_val("beat_col", 32'(m_col), 32'(e.col));
          check_val("beat_last", 32'(m_last), 32'(e.last));
        end
      end
      stall_q = m_valid && !m_ready;
      data_q  = m_data;
      row_q   = m_row;
      col_q   = m_col;
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    stall_q   = 1'b0;
    reset_n   = 1'b0;
    mat_valid = 1'b0;
    m_ready   = 1'b0;
    set_mat_seq();
    repeat (3) step();
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_m_last", 32'(m_last), 32'd0);
    check_val("rst_m_data", 32'(m_data), 32'd0);
    check_val("rst_m_row", 32'(m_row), 32'd0);
    check_val("rst_m_col", 32'(m_col), 32'd0);
    reset_n = 1'b1;
    step();

    // Test 1: single pulse, ready always high.
    m_ready = 1'b1;
    set_mat_seq();
    mat_valid = 1'b1;
    push_expected();
    check_val("t1_pre_valid", 32'(m_valid), 32'd0);
    step();
    mat_valid = 1'b0;
    check_val("t1_valid_lat1", 32'(m_valid), 32'd1);
    check_val("t1_busy", 32'(busy), 32'd1);
    drain(0, 100);
    check_val("t1_idle_valid", 32'(m_valid), 32'd0);
    check_val("t1_idle_busy", 32'(busy), 32'd0);
    check_val("t1_idle_last", 32'(m_last), 32'd0);
    repeat (2) step();

    // Test 2: ready toggled 1,0,0,...
    mat_valid = 1'b1;
    push_expected();
    step();
    mat_valid = 1'b0;
    drain(1, 200);
    check_val("t2_idle_busy", 32'(busy), 32'd0);
    repeat (2) step();

    // Test 3: mat_valid held high for 40 cycles yields exactly one stream.
    mat_valid = 1'b1;
    push_expected();
    repeat (40) step();
    mat_valid = 1'b0;
    check_val("t3_one_stream", 32'(sb.size()), 32'd0);
    check_val("t3_overflow", 32'(overflow), 32'd0);
    check_val("t3_busy", 32'(busy), 32'd0);
    step();

    // Test 4: a new edge mid-stream is dropped and overflow sticks.
    set_mat_seq();
    mat_valid = 1'b1;
    push_expected();
    step();
    mat_valid = 1'b0;
    repeat (5) step();
    set_mat_const(8'hFF);
    mat_valid = 1'b1;
    step();
    mat_valid = 1'b0;
    check_val("t4_overflow_set", 32'(overflow), 32'd1);
    drain(0, 100);
    repeat (3) step();
    check_val("t4_overflow_sticky", 32'(overflow), 32'd1);
    reset_n = 1'b0;
    step();
    check_val("t4_rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step();

    // Test 5: edge coincident with the final handshake is accepted back-to-back.
    set_mat_seq();
    mat_valid = 1'b1;
    push_expected();
    step();
    mat_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check_val("t5_valid_run", 32'(m_valid), 32'd1);
    end
    set_mat_const(8'hAA);
    mat_valid = 1'b1;
    push_expected();
    step();
    mat_valid = 1'b0;
    check_val("t5_valid_kept", 32'(m_valid), 32'd1);
    check_val("t5_row0", 32'(m_row), 32'd0);
    check_val("t5_col0", 32'(m_col), 32'd0);
    check_val("t5_data_aa", 32'(m_data), 32'hAA);
    drain(0, 100);
    check_val("t5_overflow", 32'(overflow), 32'd0);
    step();

    // Test 6: reset mid-stream discards the partial matrix at once.
    set_mat_seq();
    mat_valid = 1'b1;
    push_expected();
    step();
    mat_valid = 1'b0;
    repeat (3) step();
    mat_valid = 1'b1;
    step();
    mat_valid = 1'b0;
    check_val("t6_overflow_pre", 32'(overflow), 32'd1);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_valid", 32'(m_valid), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_overflow", 32'(overflow), 32'd0);
    check_val("t6_rst_data", 32'(m_data), 32'd0);
    sb.delete();
    step();
    reset_n = 1'b1;
    repeat (2) step();
    check_val("t6_post_valid", 32'(m_valid), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
